// File: rtl/prescaler_ctrl.sv
// prescaler_ctrl: NUM_CH clock-enable ticks and square waves from sysclk, configured over a valid/ready stream.
// Define PRESCALER_SYNC_RESTART_EN to build the SYNC_RESTART op; without it op 11 is rejected.
//
// state | meaning
// IDLE  | stopped, count held at 0, o_sq held
// RUN   | counting, tick at count == div-1
// PEND  | counting with old div, staged divisor takes over at the next terminal count
module prescaler_ctrl #(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = 16,
  parameter int  DEFAULT_DIV = 60,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic              sysclk,
  input  logic              i_rst,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [1:0]        i_cfg_op,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [CNT_W-1:0]  i_cfg_div,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_sq,
  output logic [NUM_CH-1:0] o_run,
  output logic              o_cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } ch_state_e;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_SYNC  = 2'b11;

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  div_q   [NUM_CH];
  logic [CNT_W-1:0]  div_d   [NUM_CH];
  logic [CNT_W-1:0]  stg_q   [NUM_CH];
  logic [CNT_W-1:0]  stg_d   [NUM_CH];
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic              err_q, err_d;

  logic              ch_ok;
  logic              ch_pend;
  logic              accept;
  logic              reject;
  logic              cmd_ok;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] term;

  always_comb begin : decode
    ch_ok   = 1'b0;
    ch_pend = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_cfg_ch == CH_W'(c)) begin
        ch_ok   = 1'b1;
        ch_pend = (state_q[c] == ST_PEND);
      end
    end
    o_cfg_ready = !((i_cfg_op == OP_LOAD) && ch_pend);
    accept      = i_cfg_valid && o_cfg_ready;
`ifdef PRESCALER_SYNC_RESTART_EN
    reject = accept && (i_cfg_op != OP_SYNC) &&
             (!ch_ok || ((i_cfg_op == OP_LOAD) && (i_cfg_div == '0)));
`else
    reject = accept && ((i_cfg_op == OP_SYNC) || !ch_ok ||
                        ((i_cfg_op == OP_LOAD) && (i_cfg_div == '0)));
`endif
    cmd_ok = accept && !reject;
    hit    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit[c] = cmd_ok && (i_cfg_op != OP_SYNC) && (i_cfg_ch == CH_W'(c));
    end
  end

  always_comb begin : next_state
    err_d  = reject;
    tick_d = '0;
    sq_d   = sq_q;
    term   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      div_d[c]   = div_q[c];
      stg_d[c]   = stg_q[c];
      term[c]    = (cnt_q[c] == (div_q[c] - CNT_W'(1)));

      case (state_q[c])
        ST_RUN, ST_PEND: begin
          if (term[c]) begin
            cnt_d[c]  = '0;
            tick_d[c] = 1'b1;
            sq_d[c]   = ~sq_q[c];
            if (state_q[c] == ST_PEND) begin
              div_d[c]   = stg_q[c];
              state_d[c] = ST_RUN;
            end
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        default: cnt_d[c] = '0;
      endcase

      if (hit[c]) begin
        case (i_cfg_op)
          OP_START: begin
            if (state_q[c] == ST_IDLE) begin
              state_d[c] = ST_RUN;
              cnt_d[c]   = '0;
            end
          end
          // STOP beats a coincident terminal count: no tick, no toggle, staged divisor dropped
          OP_STOP: begin
            state_d[c] = ST_IDLE;
            cnt_d[c]   = '0;
            div_d[c]   = div_q[c];
            tick_d[c]  = 1'b0;
            sq_d[c]    = sq_q[c];
          end
          OP_LOAD: begin
            if (state_q[c] == ST_IDLE) begin
              div_d[c] = i_cfg_div;
            end else if (term[c]) begin
              // old period ends on this edge, so the new divisor governs the next one directly
              div_d[c] = i_cfg_div;
            end else begin
              state_d[c] = ST_PEND;
              stg_d[c]   = i_cfg_div;
            end
          end
          default: ;
        endcase
      end

`ifdef PRESCALER_SYNC_RESTART_EN
      if (cmd_ok && (i_cfg_op == OP_SYNC)) begin
        tick_d[c] = 1'b0;
        sq_d[c]   = 1'b0;
        if (state_q[c] != ST_IDLE) begin
          cnt_d[c]   = '0;
          state_d[c] = ST_RUN;
          if (state_q[c] == ST_PEND) begin
            div_d[c] = stg_q[c];
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge sysclk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
        div_q[c]   <= CNT_W'(DEFAULT_DIV);
        stg_q[c]   <= '0;
      end
      tick_q <= '0;
      sq_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        div_q[c]   <= div_d[c];
        stg_q[c]   <= stg_d[c];
      end
      tick_q <= tick_d;
      sq_q   <= sq_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    o_run = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      o_run[c] = (state_q[c] != ST_IDLE);
    end
  end

  assign o_tick    = tick_q;
  assign o_sq      = sq_q;
  assign o_cfg_err = err_q;

endmodule

// File: tb/tb_prescaler_ctrl.sv
// Bench for prescaler_ctrl: directed scenarios, a tick-schedule model compared every cycle,
// and literal expectations at the key edges.
module tb_prescaler_ctrl;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_SYNC  = 2'b11;
`ifdef PRESCALER_SYNC_RESTART_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic           sysclk = 1'b0;
  logic           i_rst;
  logic           i_cfg_valid;
  logic [1:0]     i_cfg_op;
  logic [1:0]     i_cfg_ch;
  logic [CW-1:0]  i_cfg_div;
  logic           o_cfg_ready;
  logic [NCH-1:0] o_tick, o_sq, o_run;
  logic           o_cfg_err;

  logic           v3;
  logic [1:0]     op3;
  logic [1:0]     ch3;
  logic [CW-1:0]  div3;
  logic           rdy3;
  logic [2:0]     tick3, sq3, run3;
  logic           err3;

  always #5 sysclk = ~sysclk;

  prescaler_ctrl #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(60)) dut (
    .sysclk(sysclk), .i_rst(i_rst), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_op(i_cfg_op), .i_cfg_ch(i_cfg_ch), .i_cfg_div(i_cfg_div),
    .o_tick(o_tick), .o_sq(o_sq), .o_run(o_run), .o_cfg_err(o_cfg_err)
  );

  // three-channel build so that an out-of-range channel number is expressible
  prescaler_ctrl #(.NUM_CH(3), .CNT_W(CW), .DEFAULT_DIV(60)) dut3 (
    .sysclk(sysclk), .i_rst(i_rst), .i_cfg_valid(v3), .o_cfg_ready(rdy3),
    .i_cfg_op(op3), .i_cfg_ch(ch3), .i_cfg_div(div3),
    .o_tick(tick3), .o_sq(sq3), .o_run(run3), .o_cfg_err(err3)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // model: each running channel carries the absolute cycle of its next tick
  bit m_run  [NCH];
  bit m_pend [NCH];
  bit m_sq   [NCH];
  bit m_tick [NCH];
  int m_div  [NCH];
  int m_stg  [NCH];
  int m_next [NCH];
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_ready();
    return !((i_cfg_op == OP_LOAD) && m_pend[i_cfg_ch]);
  endfunction

  task automatic model_step();
    bit acc;
    bit stop_c;
    int c;
    int nd;
    if (i_rst) begin
      for (int k = 0; k < NCH; k++) begin
        m_run[k] = 0; m_pend[k] = 0; m_sq[k] = 0; m_tick[k] = 0;
        m_div[k] = 60; m_stg[k] = 0; m_next[k] = 0;
      end
      m_err = 0;
      return;
    end
    acc   = i_cfg_valid && exp_ready();
    m_err = acc && (((i_cfg_op == OP_LOAD) && (i_cfg_div == 0)) || ((i_cfg_op == OP_SYNC) && !SYNC_ON));
    c     = int'(i_cfg_ch);
    nd    = int'(i_cfg_div);
    for (int k = 0; k < NCH; k++) begin
      stop_c    = acc && !m_err && (i_cfg_op == OP_STOP) && (k == c);
      m_tick[k] = m_run[k] && (cyc == m_next[k]) && !stop_c;
      if (m_tick[k]) begin
        m_sq[k] = !m_sq[k];
        if (m_pend[k]) begin
          m_div[k]  = m_stg[k];
          m_pend[k] = 0;
        end
        m_next[k] = cyc + m_div[k];
      end
    end
    if (acc && !m_err) begin
      case (i_cfg_op)
        OP_START: if (!m_run[c]) begin m_run[c] = 1; m_next[c] = cyc + m_div[c]; end
        OP_STOP:  begin m_run[c] = 0; m_pend[c] = 0; end
        OP_LOAD: begin
          if (!m_run[c]) m_div[c] = nd;
          else if (m_tick[c]) begin m_div[c] = nd; m_next[c] = cyc + nd; end
          else begin m_pend[c] = 1; m_stg[c] = nd; end
        end
        default: begin
          for (int k = 0; k < NCH; k++) begin
            m_sq[k] = 0; m_tick[k] = 0;
            if (m_run[k]) begin
              if (m_pend[k]) m_div[k] = m_stg[k];
              m_pend[k] = 0;
              m_next[k] = cyc + m_div[k];
            end
          end
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge sysclk);
    cyc++;
    model_step();
  end

  initial forever begin
    logic [NCH-1:0] et, es, er;
    @(negedge sysclk);
    if (chk_en) begin
      for (int k = 0; k < NCH; k++) begin
        et[k] = m_tick[k]; es[k] = m_sq[k]; er[k] = m_run[k];
      end
      check("model o_tick", o_tick, et);
      check("model o_sq", o_sq, es);
      check("model o_run", o_run, er);
      check("model o_cfg_err", o_cfg_err, m_err);
      check("model o_cfg_ready", o_cfg_ready, exp_ready());
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic cmd(input logic [1:0] op, input int ch, input int dv);
    i_cfg_valid = 1'b1;
    i_cfg_op    = op;
    i_cfg_ch    = ch[1:0];
    i_cfg_div   = dv[CW-1:0];
    tick();
    i_cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, a, s, r, s0, s1, y;
    i_rst = 1'b1; i_cfg_valid = 1'b0; i_cfg_op = OP_LOAD; i_cfg_ch = 2'd0; i_cfg_div = '0;
    v3 = 1'b0; op3 = OP_LOAD; ch3 = 2'd0; div3 = '0;
    repeat (2) tick();
    chk_en = 1'b1;
    check("reset o_tick", o_tick, 4'b0000);
    check("reset o_sq", o_sq, 4'b0000);
    check("reset o_run", o_run, 4'b0000);
    check("reset o_cfg_err", o_cfg_err, 1'b0);
    i_rst = 1'b0;
    tick();

    // default divisor 60 on ch0
    cmd(OP_START, 0, 0); n0 = cyc;
    check("t1 run", o_run, 4'b0001);
    run_to(n0 + 59); check("t1 before 60", o_tick[0], 1'b0);
    tick();          check("t1 tick 60", o_tick, 4'b0001);
    check("t1 sq 60", o_sq[0], 1'b1);
    run_to(n0 + 120); check("t1 tick 120", o_tick[0], 1'b1);
    check("t1 sq 120", o_sq[0], 1'b0);
    run_to(n0 + 180); check("t1 tick 180", o_tick, 4'b0001);
    check("t1 sq 180", o_sq[0], 1'b1);

    // staged divisor on ch1
    cmd(OP_LOAD, 1, 10);
    cmd(OP_START, 1, 0); a = cyc;
    tick(); tick();
    cmd(OP_LOAD, 1, 4);
    i_cfg_valid = 1'b1; i_cfg_op = OP_LOAD; i_cfg_ch = 2'd1; i_cfg_div = 16'd7;
    #1; check("t2 ready while pending", o_cfg_ready, 1'b0);
    tick(); i_cfg_valid = 1'b0;
    run_to(a + 9);  check("t2 before 10", o_tick[1], 1'b0);
    tick();         check("t2 tick 10", o_tick[1], 1'b1);
    check("t2 ready after apply", o_cfg_ready, 1'b1);
    run_to(a + 13); check("t2 before 14", o_tick[1], 1'b0);
    tick();         check("t2 tick 14", o_tick[1], 1'b1);
    run_to(a + 18); check("t2 tick 18", o_tick[1], 1'b1);
    cmd(OP_STOP, 1, 0);

    // rejected commands
    cmd(OP_LOAD, 2, 0);
    check("t3 err div0", o_cfg_err, 1'b1);
    tick(); check("t3 err one cycle", o_cfg_err, 1'b0);
    cmd(OP_START, 2, 0); s = cyc;
    run_to(s + 59); check("t3 div kept pre", o_tick[2], 1'b0);
    tick();         check("t3 div kept 60", o_tick[2], 1'b1);
    cmd(OP_STOP, 2, 0);
    v3 = 1'b1; op3 = OP_LOAD; ch3 = 2'd3; div3 = 16'd5;
    #1; check("t3 u3 ready", rdy3, 1'b1);
    tick(); check("t3 u3 err load", err3, 1'b1);
    op3 = OP_START;
    tick(); v3 = 1'b0;
    check("t3 u3 err start", err3, 1'b1);
    check("t3 u3 run", run3, 3'b000);
    tick(); check("t3 u3 err clear", err3, 1'b0);

    // div=1 on ch3, STOP lands on a terminal-count edge
    cmd(OP_LOAD, 3, 1);
    cmd(OP_START, 3, 0);
    tick(); check("t4 tick a", o_tick[3], 1'b1); check("t4 sq a", o_sq[3], 1'b1);
    tick(); check("t4 tick b", o_tick[3], 1'b1); check("t4 sq b", o_sq[3], 1'b0);
    tick(); check("t4 sq c", o_sq[3], 1'b1);
    cmd(OP_STOP, 3, 0);
    check("t4 stop tick", o_tick[3], 1'b0);
    check("t4 stop run", o_run[3], 1'b0);
    check("t4 stop sq held", o_sq[3], 1'b1);
    tick(); check("t4 idle tick", o_tick[3], 1'b0);

    // reset with ch0 pending
    if (((cyc + 1 - n0) % 60) == 0) tick();
    cmd(OP_LOAD, 0, 20);
    check("t5 ready pend", o_cfg_ready, 1'b0);
    check("t5 run pend", o_run[0], 1'b1);
    i_rst = 1'b1;
    tick();
    check("t5 rst tick", o_tick, 4'b0000);
    check("t5 rst sq", o_sq, 4'b0000);
    check("t5 rst run", o_run, 4'b0000);
    check("t5 rst err", o_cfg_err, 1'b0);
    i_rst = 1'b0;
    cmd(OP_START, 0, 0); r = cyc;
    run_to(r + 20); check("t5 no staged 20", o_tick[0], 1'b0);
    run_to(r + 59); check("t5 before 60", o_tick[0], 1'b0);
    tick();         check("t5 tick 60", o_tick[0], 1'b1);

    // SYNC_RESTART
    cmd(OP_STOP, 0, 0);
    cmd(OP_LOAD, 0, 6);
    cmd(OP_LOAD, 1, 9);
    cmd(OP_START, 0, 0); s0 = cyc;
    tick(); tick();
    cmd(OP_START, 1, 0); s1 = cyc;
    tick(); tick();
    cmd(OP_SYNC, 0, 0); y = cyc;
    if (SYNC_ON) begin
      check("t6 sync sq", o_sq, 4'b0000);
      check("t6 sync err", o_cfg_err, 1'b0);
      check("t6 sync tick", o_tick, 4'b0000);
      run_to(y + 5); check("t6 ch0 before 6", o_tick[0], 1'b0);
      tick();        check("t6 ch0 tick 6", o_tick[0], 1'b1);
      run_to(y + 8); check("t6 ch1 before 9", o_tick[1], 1'b0);
      tick();        check("t6 ch1 tick 9", o_tick[1], 1'b1);
    end else begin
      check("t6 sync err", o_cfg_err, 1'b1);
      check("t6 ch0 phase kept", o_tick[0], 1'b1);
      run_to(s1 + 8); check("t6 ch1 before 9", o_tick[1], 1'b0);
      tick();         check("t6 both aligned old", o_tick[1:0], 2'b11);
    end
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
